// File: rtl/key_event_decoder.sv
// Turns a stream of ASCII-hex keyboard scan codes into held levels and one-cycle
// press/release pulses for W, A, S, D, ENTER and SPACE.
module key_event_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] key_code,
  input  logic        key_valid,
  output logic [5:0]  key_held,
  output logic [5:0]  key_pressed,
  output logic [5:0]  key_released
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [15:0] CODE_RELEASED = 16'h4630;
  localparam logic [15:0] CODE_EXTENDED = 16'h4530;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  state_t        state_r, next_state_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic [5:0]    held_next_s;
  logic [5:0]    key_mask_s;
  logic          key_hit_s;

  // One-hot mask of the tracked key a code names; zero for any other code.
  function automatic logic [5:0] key_mask(input logic [15:0] code);
    logic [5:0] m;
    case (code)
      16'h3144: m = 6'b000001;
      16'h3143: m = 6'b000010;
      16'h3142: m = 6'b000100;
      16'h3233: m = 6'b001000;
      16'h3541: m = 6'b010000;
      16'h3239: m = 6'b100000;
      default:  m = 6'b000000;
    endcase
    return m;
  endfunction

  // Decode the incoming code against the tracked keys.
  always_comb begin
    key_mask_s = key_mask(key_code);
    key_hit_s  = |key_mask_s;
  end

  // Next-state, next held levels and prefix timeout counter.
  always_comb begin
    next_state_s = state_r;
    held_next_s  = key_held;
    cnt_next_s   = {CW{1'b0}};
    if (key_valid) begin
      case (state_r)
        IDLE: begin
          if (key_code == CODE_RELEASED) begin
            next_state_s = BREAK;
          end else if (key_code == CODE_EXTENDED) begin
            next_state_s = EXT;
          end else begin
            held_next_s = key_held | key_mask_s;
          end
        end
        BREAK: begin
          if (key_hit_s) begin
            held_next_s  = key_held & ~key_mask_s;
            next_state_s = IDLE;
          end else if (key_code == CODE_RELEASED) begin
            next_state_s = BREAK;
          end else if (key_code == CODE_EXTENDED) begin
            next_state_s = EXT;
          end else begin
            next_state_s = IDLE;
          end
        end
        EXT: begin
          if (key_code == CODE_RELEASED) begin
            next_state_s = EXT_BREAK;
          end else begin
            next_state_s = IDLE;
          end
        end
        EXT_BREAK: next_state_s = IDLE;
        default:   next_state_s = IDLE;
      endcase
    end else if (state_r != IDLE) begin
      // An abandoned prefix drops back to IDLE without touching held keys.
      if (cnt_r == CNT_LAST) begin
        next_state_s = IDLE;
      end else begin
        cnt_next_s = cnt_r + CW'(1);
      end
    end else begin
      next_state_s = IDLE;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      key_held     <= 6'b000000;
      key_pressed  <= 6'b000000;
      key_released <= 6'b000000;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= cnt_next_s;
      key_held     <= held_next_s;
      key_pressed  <= held_next_s & ~key_held;
      key_released <= key_held & ~held_next_s;
    end
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the keyboard receive path; consumes the 16-bit two-character ASCII-hex scan codes defined in keyboardPkg.
- Codes arrive one per key_valid strobe.
- Tracks make/break sequences (RELEASED prefix, E0 extended prefix) and produces per-key held levels plus one-cycle press/release pulses for game logic: W, A, S, D, ENTER, SPACE.

Parameters:
- TIMEOUT_CYCLES, 2_000_000: cycles a prefix state may wait for its follow-up code before abandoning it; must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_code  input  16  ASCII-hex scan code, e.g. 'h3144 = W, 'h4630 = RELEASED, 'h4530 = EXTENDED ("E0")
- key_valid  input  1  one-cycle strobe; key_code is valid in the same cycle
- key_held  output  6  level per key: [0]=W [1]=A [2]=S [3]=D [4]=ENTER [5]=SPACE
- key_pressed  output  6  one-cycle pulse on a 0->1 transition of key_held, same bit map
- key_released  output  6  one-cycle pulse on a 1->0 transition of key_held, same bit map

Behaviour:
- Reset (async assert, sync release): key_held = 0, key_pressed = 0, key_released = 0, FSM = IDLE, timeout counter = 0.
- All outputs are registered. A code accepted at edge N updates key_held, and pulses key_pressed/key_released, visible after edge N. Latency is 1 cycle.
- Pulses last exactly one cycle and clear in the next cycle unless a new event occurs.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK.
- In IDLE, on key_valid:
  - RELEASED -> BREAK.
  - EXTENDED -> EXT.
  - Mapped code -> set that held bit. Pulse pressed only if the bit was 0; typematic repeats of a held key give no pulse.
  - Any other code -> ignored, stay IDLE.
- In BREAK, on key_valid:
  - Mapped code -> clear that held bit. Pulse released only if the bit was 1. Go to IDLE.
  - RELEASED -> stay BREAK, restart timer.
  - EXTENDED -> EXT.
  - Other -> IDLE, no change.
- In EXT, on key_valid:
  - RELEASED -> EXT_BREAK.
  - Anything else -> IDLE, no change. Extended keys never alias onto mapped keys.
- In EXT_BREAK, on key_valid: any code -> IDLE, no change.
- Timeout:
  - The counter runs only in BREAK, EXT and EXT_BREAK. It resets to 0 on every state entry and on every accepted code.
  - When the counter reaches TIMEOUT_CYCLES-1 without key_valid, the FSM returns to IDLE and key_held is unchanged.
  - If key_valid arrives in the same cycle as the timeout, key_valid takes priority and is processed in the current state.
- Only one key_code is processed per cycle; key_valid held high for consecutive cycles is processed as consecutive codes.
- key_code is ignored when key_valid = 0.
- Reset asserted mid-sequence (e.g. in BREAK) clears everything immediately. No pulses are emitted for keys that were held.

Test Plan:
- Reset, then key_valid with 'h3144 (W) -> next cycle key_held = 6'b000001, key_pressed = 6'b000001 for exactly one cycle.
- W held, then 'h3144 three more times (repeat) -> key_held stays 6'b000001, key_pressed stays 0.
- W held, then 'h4630 followed by 'h3144 -> key_held = 0, key_released = 6'b000001 for one cycle, FSM back in IDLE.
- Press A ('h3143) and D ('h3233), release A only -> key_held = 6'b001000, key_released = 6'b000010.
- 'h4530, 'h3233 (extended code aliasing D) -> key_held unchanged at 0, no pulses. Then 'h4530, 'h4630, 'h3233 -> still no change.
- 'h4630 then no code for TIMEOUT_CYCLES (set to 16 in bench) -> FSM in IDLE after cycle 16; subsequent 'h3239 sets key_held[5] = 1 with a key_pressed[5] pulse.
- Also cover: key_valid arriving exactly on the timeout cycle -> treated as a break target.
- Also cover: rst_n asserted while in BREAK with W held -> all outputs 0 asynchronously.
